// File: rtl/evr_tx_framer_pkg.sv
// ---------------------------------------------------------------------------
// evr_tx_framer_pkg
// Shared definitions for the event-generator transmit framer:
//   - 8b/10b K-character codes used on the EVG->EVR link (also used by the
//     EVR-side decoders, so keep values in sync with them)
//   - buffer-stream framing FSM state type
// No ports (package).
// ---------------------------------------------------------------------------
package evr_tx_framer_pkg;

    localparam logic [7:0] K28_5    = 8'hBC;  // comma, event lane alignment
    localparam logic [7:0] K28_0    = 8'h1C;  // data-buffer frame start
    localparam logic [7:0] K28_1    = 8'h3C;  // data-buffer frame end
    localparam logic [7:0] NULL_EVT = 8'h00;  // "no event" code

    typedef enum logic [1:0] {
        BUF_IDLE = 2'd0,
        BUF_DATA = 2'd1,
        BUF_END  = 2'd2
    } buf_state_e;

endpackage

// File: rtl/evr_tx_evt_fifo.sv
// ---------------------------------------------------------------------------
// evr_tx_evt_fifo
// Synchronous first-word-fall-through FIFO holding pending event codes.
// Ports:
//   clk_i        in   clock, rising edge
//   rst_i        in   synchronous active-high reset (empties the FIFO)
//   push_i       in   write data_i (ignored when full)
//   data_i       in   8-bit event code
//   pop_i        in   discard head entry (ignored when empty)
//   data_o       out  head entry, valid whenever empty_o is low
//   empty_o      out  FIFO empty
//   full_o       out  FIFO full
//   full_next_o  out  FIFO will be full after this cycle's push/pop
//   level_o      out  occupancy 0..2**AW
// ---------------------------------------------------------------------------
module evr_tx_evt_fifo #(
    parameter int AW = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  logic [7:0]    data_i,
    input  logic          pop_i,
    output logic [7:0]    data_o,
    output logic          empty_o,
    output logic          full_o,
    output logic          full_next_o,
    output logic [AW:0]   level_o
);

    localparam int DEPTH = 2 ** AW;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   level_q;
    logic [AW:0]   level_d;
    logic          do_push;
    logic          do_pop;

    assign empty_o     = (level_q == '0);
    assign full_o      = (level_q == (AW+1)'(DEPTH));
    assign do_push     = push_i && !full_o;
    assign do_pop      = pop_i && !empty_o;
    assign level_d     = level_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    assign full_next_o = (level_d == (AW+1)'(DEPTH));
    assign data_o      = mem_q[rd_ptr_q];
    assign level_o     = level_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            level_q <= level_d;
        end
    end

    // Storage is plain data; pointers alone define what is valid.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/evr_tx_framer.sv
// ---------------------------------------------------------------------------
// evr_tx_framer
// Event-generator transmit framer producing the 16-bit 8b/10b parallel word
// stream for an MGT TX channel.
//   byte1 [15:8] : event lane, K28.5 comma every COMMA_PERIOD words
//   byte0 [7:0]  : even slots = distributed bus, odd slots = K28.0/K28.1
//                  framed data-buffer stream
// Ports:
//   ref_clk        in   TX user clock
//   reset          in   synchronous active-high reset
//   tx_enable      in   0 = comma-only idle output, FIFO held, frame aborted
//   evt_code       in   event code (8'h00 accepted but dropped)
//   evt_valid      in   event valid
//   evt_ready      out  event FIFO not full
//   dbus_in        in   distributed bus byte (even slots)
//   buf_data       in   data-buffer payload byte
//   buf_valid      in   payload byte valid
//   buf_last       in   final payload byte of frame
//   buf_ready      out  payload byte consumed this cycle
//   tx_data        out  parallel word to MGT
//   tx_charisk     out  per-byte K flag
//   evt_fifo_level out  event FIFO occupancy
//   evt_deferred   out  head event held back by a comma slot (pulse)
// ---------------------------------------------------------------------------
module evr_tx_framer
    import evr_tx_framer_pkg::*;
#(
    parameter int COMMA_PERIOD = 16,
    parameter int EVT_FIFO_AW  = 4
) (
    input  logic                 ref_clk,
    input  logic                 reset,
    input  logic                 tx_enable,
    input  logic [7:0]           evt_code,
    input  logic                 evt_valid,
    output logic                 evt_ready,
    input  logic [7:0]           dbus_in,
    input  logic [7:0]           buf_data,
    input  logic                 buf_valid,
    input  logic                 buf_last,
    output logic                 buf_ready,
    output logic [15:0]          tx_data,
    output logic [1:0]           tx_charisk,
    output logic [EVT_FIFO_AW:0] evt_fifo_level,
    output logic                 evt_deferred
);

    localparam int            CW       = $clog2(COMMA_PERIOD);
    localparam logic [CW-1:0] CNT_LAST = CW'(COMMA_PERIOD - 1);

    logic [CW-1:0] comma_cnt_q;
    logic          slot_q;
    buf_state_e    state_q, state_d;
    logic [15:0]   tx_data_q;
    logic [1:0]    tx_charisk_q;
    logic          evt_ready_q;
    logic          evt_deferred_q;

    logic [7:0]    byte1_d, byte0_d;
    logic          k1_d, k0_d;
    logic          deferred_d;
    logic          buf_ready_d;
    logic          is_comma;
    logic          evt_push, evt_pop;
    logic [7:0]    fifo_head;
    logic          fifo_empty, fifo_full, fifo_full_next;

    assign is_comma = (comma_cnt_q == '0);
    // Null events complete the handshake but never occupy a FIFO entry.
    assign evt_push = evt_valid && evt_ready_q && (evt_code != NULL_EVT);
    assign evt_pop  = tx_enable && !is_comma && !fifo_empty;

    evr_tx_evt_fifo #(.AW(EVT_FIFO_AW)) u_evt_fifo (
        .clk_i       (ref_clk),
        .rst_i       (reset),
        .push_i      (evt_push),
        .data_i      (evt_code),
        .pop_i       (evt_pop),
        .data_o      (fifo_head),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full),
        .full_next_o (fifo_full_next),
        .level_o     (evt_fifo_level)
    );

    always_comb begin
        state_d     = state_q;
        byte1_d     = NULL_EVT;
        k1_d        = 1'b0;
        byte0_d     = 8'h00;
        k0_d        = 1'b0;
        deferred_d  = 1'b0;
        buf_ready_d = 1'b0;
        if (!tx_enable) begin
            byte1_d = K28_5;
            k1_d    = 1'b1;
            state_d = BUF_IDLE;
        end else begin
            if (is_comma) begin
                byte1_d    = K28_5;
                k1_d       = 1'b1;
                deferred_d = !fifo_empty;
            end else if (!fifo_empty) begin
                byte1_d = fifo_head;
            end
            if (!slot_q) begin
                byte0_d = dbus_in;
            end else begin
                unique case (state_q)
                    BUF_IDLE: begin
                        // Start delimiter only; the first payload byte waits for the next odd slot.
                        if (buf_valid) begin
                            byte0_d = K28_0;
                            k0_d    = 1'b1;
                            state_d = BUF_DATA;
                        end
                    end
                    BUF_DATA: begin
                        if (buf_valid) begin
                            byte0_d     = buf_data;
                            buf_ready_d = 1'b1;
                            if (buf_last) state_d = BUF_END;
                        end
                    end
                    BUF_END: begin
                        byte0_d = K28_1;
                        k0_d    = 1'b1;
                        state_d = BUF_IDLE;
                    end
                    default: state_d = BUF_IDLE;
                endcase
            end
        end
    end

    assign buf_ready = buf_ready_d && !reset;

    // Output register stage: word built this cycle appears after the edge.
    always_ff @(posedge ref_clk) begin
        if (reset) begin
            comma_cnt_q    <= '0;
            slot_q         <= 1'b0;
            state_q        <= BUF_IDLE;
            tx_data_q      <= {K28_5, 8'h00};
            tx_charisk_q   <= 2'b10;
            evt_ready_q    <= 1'b0;
            evt_deferred_q <= 1'b0;
        end else begin
            comma_cnt_q    <= (comma_cnt_q == CNT_LAST) ? '0 : comma_cnt_q + CW'(1);
            slot_q         <= !slot_q;
            state_q        <= state_d;
            tx_data_q      <= {byte1_d, byte0_d};
            tx_charisk_q   <= {k1_d, k0_d};
            // Registered ready tracks next-cycle fullness so it equals !full while in use.
            evt_ready_q    <= !fifo_full_next;
            evt_deferred_q <= deferred_d;
        end
    end

    assign tx_data      = tx_data_q;
    assign tx_charisk   = tx_charisk_q;
    assign evt_ready    = evt_ready_q;
    assign evt_deferred = evt_deferred_q;

endmodule
